seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Parametrised multi-cycle shift/rotate unit for the ALU datapath.
- Successor to the single-bit left/right register shifter. Adds:
  - a load/start handshake;
  - a programmable shift amount;
  - logical, arithmetic and rotate modes;
  - a configurable number of bit positions per cycle;
  - carry-out and done signalling.
- Sits beside the adder/logic units. The ALU sequencer issues a start and waits for done.

Parameters:
- N, 32, operand width in bits (>= 2).
- STEP, 1, maximum bit positions shifted per clock (1..N).
- SW, $clog2(N), width of the shift-amount field (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; accepted only when ready=1.
- a  input  N  operand, captured on accept.
- amt  input  SW  shift amount 0..N-1, captured on accept.
- mode  input  2  operation select, captured on accept: 00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- dir  input  1  direction, captured on accept: 0 left, 1 right.
- ready  output  1  high in IDLE.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse when y is final.
- y  output  N  working/result register. Holds its value until the next accept.
- carry  output  1  last bit shifted or rotated out; 0 when amt=0.

Behaviour:
- Reset: state=IDLE; y=0, carry=0, done=0, busy=0, ready=1. Reset mid-operation aborts the operation, and no done is issued.
- States are IDLE, SHIFT and DONE.
- IDLE, on start=1:
  - Load y<=a and rem<=amt; latch mode and dir.
  - Clear carry.
  - Next state is SHIFT if amt!=0, otherwise DONE.
- SHIFT, each cycle:
  - Shift y by k=min(STEP, rem); rem<=rem-k.
  - carry<= the last bit moved out (for rotate, the bit that wrapped).
  - When rem-k==0, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. ready=0 during DONE.
- Latency: done is asserted ceil(amt/STEP)+1 cycles after the accepting edge. amt=0 gives done 1 cycle after accept, with y=a.
- Logical left/right: vacated bits are 0.
- Arithmetic right: vacated bits equal the sign bit a[N-1]. Arithmetic left is identical to logical left.
- Rotate: no bits are lost; the direction is given by dir.
- start while busy or in DONE is ignored; there is no queuing.
- Inputs other than start are don't-care outside the accept cycle.
- amt is always < N, so no over-shift handling is needed.

Optional Feature:
- SEQ_SHIFTER_BARREL_EN
- When defined:
  - The SHIFT state is bypassed. A combinational barrel network computes the full result from a, amt, mode and dir on accept.
  - y and carry are registered at the accept edge; the state goes to DONE.
  - done is asserted 1 cycle after accept for every amt. STEP is ignored.
- When undefined: the iterative behaviour above applies. Results must be bit-identical in both builds.

Decomposition:
- Package seq_shifter_pkg holds:
  - the mode encodings (MODE_LOGIC, MODE_ARITH, MODE_ROT);
  - the direction constants (DIR_LEFT, DIR_RIGHT);
  - the state enum (ST_IDLE, ST_SHIFT, ST_DONE).
- One sub-module, shift_stage: a combinational shift of up to STEP positions with mode/dir/sign inputs, returning the shifted word and carry. It is reused by the barrel build as a log2 cascade.

Test Plan (N=32, STEP=1 unless stated):
- Logical left, a=0x0000_0001, amt=4, dir=0 -> y=0x0000_0010, carry=0, done 5 cycles after accept.
- Arithmetic right, a=0x8000_0000, amt=31 -> y=0xFFFF_FFFF, carry=0. Logical right on the same a and amt -> y=0x0000_0001.
- Rotate right, a=0x0000_0001, amt=1 -> y=0x8000_0000, carry=1. Rotate left, a=0x8000_0001, amt=4 -> y=0x0000_0018, carry=0.
- amt=0, a=0xDEAD_BEEF -> y=0xDEAD_BEEF, carry=0, done 1 cycle after accept.
- STEP=8, logical right, a=0xFF00_0000, amt=20 -> y=0x0000_0FF0, done 4 cycles after accept (3 shift cycles plus 1).
- Pulse start again mid-shift -> ignored and the first result is unchanged. Assert rst mid-shift -> the next cycle shows y=0, ready=1, and done never pulses.

Source files
------------

// File: rtl/seq_shifter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shifter_pkg
//  Description : Shared encodings for the sequential shift/rotate unit:
//                operation modes, direction constants and controller states.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_shifter_pkg;

    // Operation select; 2'b11 is reserved and behaves as MODE_LOGIC.
    localparam logic [1:0] MODE_LOGIC = 2'b00;
    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;

    // Shift direction.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : seq_shifter_pkg
`default_nettype wire

// File: rtl/seq_shifter_shift_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift_stage
//  Description : Combinational shift/rotate of din by k positions (k < N).
//                Logical fill is 0, arithmetic right fills with 'sign',
//                rotate wraps the outgoing bits. cout is the last bit moved
//                out of the word (the wrapped bit for rotate), 0 when k=0.
//                Used singly by the iterative build and as a log2 cascade by
//                the barrel build.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_stage
    import seq_shifter_pkg::*;
#(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  din,
    input  logic [SW-1:0] k,
    input  logic [1:0]    mode,
    input  logic          dir,
    input  logic          sign,
    output logic [N-1:0]  dout,
    output logic          cout
);

    localparam logic [SW:0]  c_n    = (SW+1)'(N);
    localparam logic [N-1:0] c_ones = '1;

    logic [SW:0]   w_nk;    // N-k: index of last bit leaving on a left shift
    logic [SW-1:0] w_km1;   // k-1: index of last bit leaving on a right shift

    assign w_nk  = c_n - {1'b0, k};
    assign w_km1 = k - SW'(1);

    // Shift the word and pick the last outgoing bit.
    always_comb begin
        dout = din;
        cout = 1'b0;
        if (dir == DIR_LEFT) begin
            // Arithmetic left is the same as logical left.
            dout = din << k;
            if (mode == MODE_ROT) begin
                dout = dout | (din >> w_nk);
            end
            if (k != '0) begin
                cout = din[w_nk[SW-1:0]];
            end
        end else begin
            dout = din >> k;
            if (mode == MODE_ARITH) begin
                dout = dout | (sign ? ~(c_ones >> k) : '0);
            end else if (mode == MODE_ROT) begin
                dout = dout | (din << w_nk);
            end
            if (k != '0) begin
                cout = din[w_km1];
            end
        end
    end

endmodule : shift_stage
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shifter
//  Description : Multi-cycle shift/rotate unit with start/ready/done
//                handshake. Shifts up to STEP positions per clock until the
//                programmed amount is consumed. Logical, arithmetic and
//                rotate modes, left or right, with carry-out.
//                Optional build macro SEQ_SHIFTER_BARREL_EN replaces the
//                iterative SHIFT phase with a single-cycle barrel network;
//                results are bit-identical in both builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = 1,
    parameter int SW   = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  a,
    input  logic [SW-1:0] amt,
    input  logic [1:0]    mode,
    input  logic          dir,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  y,
    output logic          carry
);

    state_t r_state;
    state_t w_next;
    logic   w_accept;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign ready    = (r_state == ST_IDLE);
    assign busy     = (r_state == ST_SHIFT);
    assign done     = (r_state == ST_DONE);

`ifdef SEQ_SHIFTER_BARREL_EN
    // ------------------------------------------------------------------
    // Barrel build: stage i shifts by 2**i when amt[i] is set. The carry
    // of the last active stage is the overall last bit shifted out.
    // ------------------------------------------------------------------
    logic [SW:0][N-1:0] w_bar_y;
    logic [SW:0]        w_bar_c;

    assign w_bar_y[0] = a;
    assign w_bar_c[0] = 1'b0;

    for (genvar gi = 0; gi < SW; gi++) begin : g_barrel
        localparam logic [SW-1:0] c_k = SW'(1) << gi;
        logic [N-1:0] w_y;
        logic         w_c;

        shift_stage #(
            .N  (N),
            .SW (SW)
        ) u_stage (
            .din  (w_bar_y[gi]),
            .k    (amt[gi] ? c_k : '0),
            .mode (mode),
            .dir  (dir),
            .sign (a[N-1]),
            .dout (w_y),
            .cout (w_c)
        );

        assign w_bar_y[gi+1] = w_y;
        assign w_bar_c[gi+1] = amt[gi] ? w_c : w_bar_c[gi];
    end

    // Next-state logic: every accepted request completes in one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_DONE;
            ST_SHIFT: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Result register: full barrel result captured at the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            y     <= '0;
            carry <= 1'b0;
        end else if (w_accept) begin
            y     <= w_bar_y[SW];
            carry <= w_bar_c[SW];
        end
    end
`else
    // ------------------------------------------------------------------
    // Iterative build: one shift_stage applied min(STEP, rem) per cycle.
    // ------------------------------------------------------------------
    localparam logic [SW:0] c_step = (SW+1)'(STEP);

    logic [SW-1:0] r_rem;
    logic [1:0]    r_mode;
    logic          r_dir;
    logic          r_sign;
    logic [SW-1:0] w_k;
    logic          w_last;
    logic [N-1:0]  w_stg_y;
    logic          w_stg_c;

    // Positions to move this cycle; STEP may equal N, so compare one bit wider.
    assign w_k    = ({1'b0, r_rem} >= c_step) ? c_step[SW-1:0] : r_rem;
    assign w_last = (r_rem == w_k);

    shift_stage #(
        .N  (N),
        .SW (SW)
    ) u_stage (
        .din  (y),
        .k    (w_k),
        .mode (r_mode),
        .dir  (r_dir),
        .sign (r_sign),
        .dout (w_stg_y),
        .cout (w_stg_c)
    );

    // Next-state logic: zero-amount requests skip straight to DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = (amt != '0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Working register: load on accept, then shift while in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            y      <= '0;
            carry  <= 1'b0;
            r_rem  <= '0;
            r_mode <= MODE_LOGIC;
            r_dir  <= DIR_LEFT;
            r_sign <= 1'b0;
        end else if (w_accept) begin
            y      <= a;
            carry  <= 1'b0;
            r_rem  <= amt;
            r_mode <= mode;
            r_dir  <= dir;
            r_sign <= a[N-1];
        end else if (r_state == ST_SHIFT) begin
            y      <= w_stg_y;
            carry  <= w_stg_c;
            r_rem  <= r_rem - w_k;
        end
    end
`endif

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

endmodule : seq_shifter
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_shifter
//  Description : Self-checking bench for seq_shifter. Two instances
//                (STEP=1 and STEP=8) share operand inputs; expected results
//                are queued at issue time and compared when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;

    localparam int N  = 32;
    localparam int SW = $clog2(N);

    typedef struct {
        logic [N-1:0] y;
        logic         c;
        int           lat;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic          start1, start8;
    logic [N-1:0]  a;
    logic [SW-1:0] amt;
    logic [1:0]    mode;
    logic          dir;
    logic          rdy1, busy1, done1, c1;
    logic          rdy8, busy8, done8, c8;
    logic [N-1:0]  y1, y8;

    always #5 clk = ~clk;

    seq_shifter #(.N(N), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .amt(amt), .mode(mode),
        .dir(dir), .ready(rdy1), .busy(busy1), .done(done1), .y(y1), .carry(c1)
    );

    seq_shifter #(.N(N), .STEP(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a), .amt(amt), .mode(mode),
        .dir(dir), .ready(rdy8), .busy(busy8), .done(done8), .y(y8), .carry(c8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: one position per iteration.
    function automatic void ref_shift(input logic [N-1:0] ta, input logic [SW-1:0] tamt,
                                      input logic [1:0] tm, input logic td,
                                      output logic [N-1:0] ry, output logic rc);
        logic [N-1:0] v;
        logic         c;
        logic         fill;
        v = ta;
        c = 1'b0;
        for (int i = 0; i < int'(tamt); i++) begin
            if (td == 1'b0) begin
                c = v[N-1];
                v = {v[N-2:0], (tm == 2'b10) ? c : 1'b0};
            end else begin
                fill = (tm == 2'b10) ? v[0] : ((tm == 2'b01) ? v[N-1] : 1'b0);
                c    = v[0];
                v    = {fill, v[N-1:1]};
            end
        end
        ry = v;
        rc = c;
    endfunction

    function automatic int exp_lat(input int which, input int tamt);
`ifdef SEQ_SHIFTER_BARREL_EN
        return 1 + 0 * (which + tamt);
`else
        int step;
        step = (which != 0) ? 8 : 1;
        return (tamt + step - 1) / step + 1;
`endif
    endfunction

    task automatic issue(input int which, input logic [N-1:0] ta, input logic [SW-1:0] tamt,
                         input logic [1:0] tm, input logic td,
                         input logic [N-1:0] ey, input logic ec, input string tag);
        exp_t e;
        @(negedge clk);
        check({tag, "_ready"}, 32'((which != 0) ? rdy8 : rdy1), 32'd1);
        a    = ta;
        amt  = tamt;
        mode = tm;
        dir  = td;
        if (which != 0) start8 = 1'b1; else start1 = 1'b1;
        e.y   = ey;
        e.c   = ec;
        e.lat = exp_lat(which, int'(tamt));
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start8 = 1'b0;
    endtask

    // lat0 = cycles already elapsed since the accepting edge (1 right after it).
    task automatic wait_result(input int which, input int lat0);
        int   lat;
        exp_t e;
        lat = lat0;
        while (!((which != 0) ? done8 : done1) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check({e.tag, "_done"},  32'((which != 0) ? done8 : done1), 32'd1);
        check({e.tag, "_y"},     (which != 0) ? y8 : y1, e.y);
        check({e.tag, "_carry"}, 32'((which != 0) ? c8 : c1), 32'(e.c));
        check({e.tag, "_lat"},   32'(lat), 32'(e.lat));
        check({e.tag, "_ready_in_done"}, 32'((which != 0) ? rdy8 : rdy1), 32'd0);
        @(posedge clk);
        #1;
        check({e.tag, "_pulse"}, 32'((which != 0) ? done8 : done1), 32'd0);
        check({e.tag, "_hold"},  (which != 0) ? y8 : y1, e.y);
    endtask

    initial begin
        logic [N-1:0]  ry;
        logic          rc;
        logic [N-1:0]  ra;
        logic [SW-1:0] ramt;
        logic [1:0]    rm;
        logic          rd;
        bit            seen;

        rst = 1'b1; start1 = 1'b0; start8 = 1'b0;
        a = '0; amt = '0; mode = 2'b00; dir = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y",     y1, 32'h0);
        check("rst_carry", 32'(c1), 32'd0);
        check("rst_ready", 32'(rdy1), 32'd1);
        check("rst_busy",  32'(busy1), 32'd0);
        check("rst_done",  32'(done1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        issue(0, 32'h0000_0001, 5'd4,  2'b00, 1'b0, 32'h0000_0010, 1'b0, "lsl4");
        wait_result(0, 1);
        issue(0, 32'h8000_0000, 5'd31, 2'b01, 1'b1, 32'hFFFF_FFFF, 1'b0, "asr31");
        wait_result(0, 1);
        issue(0, 32'h8000_0000, 5'd31, 2'b00, 1'b1, 32'h0000_0001, 1'b0, "lsr31");
        wait_result(0, 1);
        issue(0, 32'h0000_0001, 5'd1,  2'b10, 1'b1, 32'h8000_0000, 1'b1, "ror1");
        wait_result(0, 1);
        issue(0, 32'h8000_0001, 5'd4,  2'b10, 1'b0, 32'h0000_0018, 1'b0, "rol4");
        wait_result(0, 1);
        issue(0, 32'hDEAD_BEEF, 5'd0,  2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0, "amt0");
        wait_result(0, 1);
        issue(1, 32'hFF00_0000, 5'd20, 2'b00, 1'b1, 32'h0000_0FF0, 1'b0, "s8_lsr20");
        wait_result(1, 1);
        issue(1, 32'hF000_000F, 5'd4,  2'b11, 1'b1, 32'h0F00_0000, 1'b1, "s8_rsvd");
        wait_result(1, 1);
        issue(1, 32'h8000_0001, 5'd17, 2'b10, 1'b0, 32'h0003_0000, 1'b0, "s8_rol17");
        wait_result(1, 1);

        // Random cases against the bit-serial model.
        for (int i = 0; i < 8; i++) begin
            ra   = $urandom;
            ramt = SW'($urandom_range(0, N - 1));
            rm   = 2'($urandom_range(0, 3));
            rd   = 1'($urandom_range(0, 1));
            ref_shift(ra, ramt, rm, rd, ry, rc);
            issue(i % 2, ra, ramt, rm, rd, ry, rc, $sformatf("rnd%0d", i));
            wait_result(i % 2, 1);
        end

        // Start pulsed mid-shift must be ignored.
        ref_shift(32'h1234_5678, 5'd10, 2'b00, 1'b0, ry, rc);
        issue(0, 32'h1234_5678, 5'd10, 2'b00, 1'b0, ry, rc, "midstart");
        @(posedge clk);
        #1;
`ifndef SEQ_SHIFTER_BARREL_EN
        check("midstart_busy", 32'(busy1), 32'd1);
`endif
        @(negedge clk);
        a = 32'hFFFF_FFFF; amt = 5'd1; mode = 2'b10; dir = 1'b1; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
`ifdef SEQ_SHIFTER_BARREL_EN
        sb.delete();
`else
        wait_result(0, 3);
`endif

        // Reset mid-shift aborts with no done.
        @(negedge clk);
        a = 32'hA5A5_A5A5; amt = 5'd20; mode = 2'b00; dir = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_y",     y1, 32'h0);
        check("abort_ready", 32'(rdy1), 32'd1);
        check("abort_busy",  32'(busy1), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done1) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_shifter
`default_nettype wire
